// File: rtl/demux_1x2_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

  // Channel indices, typed to match the 1-bit target selector.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Routing mode encodings.
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Default widths.
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/demux_1x2_stream_if.sv
// Handshake bundle between producer, demux and the two channel consumers.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry flow control in opposite directions.
interface demux_1x2_stream_if #(
  parameter int DATA_W = demux_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic              in_sel;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;

  // Environment side: drives input words, consumes output channels.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1
  );
endinterface

// File: rtl/demux_out_slot.sv
// One output channel: holding register, valid flag and saturating transfer counter.
// Latency: load at edge N is visible at N+1.
// Backpressure: data held while valid & ~ready; load and drain in one cycle keeps valid high.
module demux_out_slot #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  logic drain;
  assign drain = valid & ready;

  // Valid flag: a load wins over a drain so back-to-back words stream at full rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (drain) valid <= 1'b0;
  end

  // Holding register only changes on a load; it keeps its last value after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data <= '0;
    else if (load) data <= load_data;
  end

  // Count completed output transfers, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (drain && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 demux steering words by explicit select or round-robin.
// Latency: one cycle from input accept to output valid.
// Backpressure: in_ready combinational from target slot state and its drain.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  demux_1x2_stream_if.slave   bus,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1
);

  logic       rr;
  logic       tgt;
  logic [1:0] valid;
  logic [1:0] drain;
  logic       fire;
  logic       load0;
  logic       load1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;

  // Steering: a slot can accept when empty or emptying this same cycle.
  always_comb begin
    tgt          = (mode == MODE_RR) ? rr : bus.in_sel;
    drain        = valid & bus.out_ready;
    bus.in_ready = enable & (~valid[tgt] | drain[tgt]);
    fire         = bus.in_valid & bus.in_ready;
    load0        = fire & (tgt == CH0);
    load1        = fire & (tgt == CH1);
  end

  // Round-robin pointer advances only on an accepted word in round-robin mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          rr <= 1'b0;
    else if (fire && mode == MODE_RR) rr <= ~rr;
  end

  demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (bus.in_data),
    .ready     (bus.out_ready[0]),
    .valid     (valid[0]),
    .data      (data0),
    .cnt       (cnt0)
  );

  demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (bus.in_data),
    .ready     (bus.out_ready[1]),
    .valid     (valid[1]),
    .data      (data1),
    .cnt       (cnt1)
  );

  assign bus.out_valid = valid;
  assign bus.out_data0 = data0;
  assign bus.out_data1 = data1;

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Directed self-checking bench for demux_1x2_stream.
// Inputs change 1ns after the rising edge; outputs are compared 1-2ns after it.
// Counter width is 2 so saturation is reachable quickly.
module tb_demux_1x2_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic mode;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int checks = 0;
  int errors = 0;

  demux_1x2_stream_if #(.DATA_W(DATA_W)) bus ();

  demux_1x2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .bus    (bus),
    .cnt0   (cnt0),
    .cnt1   (cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    bus.out_ready = 2'b00;
    enable = 1'b1;
    mode   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    // Put rr at 1 and cnt0 at 1 via one round-robin word.
    mode = 1'b1;
    bus.out_ready = 2'b11;
    drive(1'b1, 1'b1, 8'h55);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
    // Fill both channels in select mode.
    mode = 1'b0;
    bus.out_ready = 2'b00;
    drive(1'b1, 1'b0, 8'hAA);
    tick();
    drive(1'b1, 1'b1, 8'hBB);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.out_valid !== 2'b11 || cnt0 !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_state out_valid=%b cnt0=%0d required 11 1", bus.out_valid, cnt0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 2'b00 || cnt0 !== 2'd0 || cnt1 !== 2'd0 ||
        bus.out_data0 !== 8'h00 || bus.out_data1 !== 8'h00) begin
      errors++;
      $display("FAIL async_reset out_valid=%b cnt0=%0d cnt1=%0d d0=%h d1=%h required 00 0 0 00 00",
               bus.out_valid, cnt0, cnt1, bus.out_data0, bus.out_data1);
    end
    tick();
    rst = 1'b0;
    enable = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset in_ready=%b required 1", bus.in_ready);
    end
    // rr must be back at 0: the next round-robin word lands in channel 0.
    mode = 1'b1;
    drive(1'b1, 1'b1, 8'h77);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.out_valid !== 2'b01 || bus.out_data0 !== 8'h77) begin
      errors++;
      $display("FAIL rr_after_reset out_valid=%b d0=%h required 01 77", bus.out_valid, bus.out_data0);
    end
  endtask

  task automatic test_select();
    do_reset();
    bus.out_ready = 2'b11;
    drive(1'b1, 1'b0, 8'hA5);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sel_ready in_ready=%b required 1", bus.in_ready);
    end
    tick();
    drive(1'b1, 1'b1, 8'h3C);
    checks++;
    if (bus.out_valid !== 2'b01 || bus.out_data0 !== 8'hA5) begin
      errors++;
      $display("FAIL sel_ch0 out_valid=%b d0=%h required 01 a5", bus.out_valid, bus.out_data0);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.out_valid !== 2'b10 || bus.out_data1 !== 8'h3C || cnt0 !== 2'd1) begin
      errors++;
      $display("FAIL sel_ch1 out_valid=%b d1=%h cnt0=%0d required 10 3c 1",
               bus.out_valid, bus.out_data1, cnt0);
    end
    tick();
    checks++;
    if (bus.out_valid !== 2'b00 || cnt0 !== 2'd1 || cnt1 !== 2'd1) begin
      errors++;
      $display("FAIL sel_counts out_valid=%b cnt0=%0d cnt1=%0d required 00 1 1",
               bus.out_valid, cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 2'b00;
    drive(1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b1, 1'b0, 8'h22);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 2'b01 || bus.out_data0 !== 8'h11) begin
      errors++;
      $display("FAIL bp_hold in_ready=%b out_valid=%b d0=%h required 0 01 11",
               bus.in_ready, bus.out_valid, bus.out_data0);
    end
    tick();
    checks++;
    if (bus.out_data0 !== 8'h11 || cnt0 !== 2'd0) begin
      errors++;
      $display("FAIL bp_stable d0=%h cnt0=%0d required 11 0", bus.out_data0, cnt0);
    end
    bus.out_ready = 2'b01;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release in_ready=%b required 1", bus.in_ready);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    bus.out_ready = 2'b00;
    checks++;
    if (bus.out_valid !== 2'b01 || bus.out_data0 !== 8'h22 || cnt0 !== 2'd1) begin
      errors++;
      $display("FAIL bp_reload out_valid=%b d0=%h cnt0=%0d required 01 22 1",
               bus.out_valid, bus.out_data0, cnt0);
    end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] got;
    do_reset();
    mode = 1'b1;
    bus.out_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'(i + 1));
      tick();
      got = (i % 2 == 0) ? bus.out_data0 : bus.out_data1;
      checks++;
      if (bus.out_valid !== 2'(1 << (i % 2)) || got !== 8'(i + 1)) begin
        errors++;
        $display("FAIL rr_word%0d out_valid=%b data=%h required %b %h",
                 i, bus.out_valid, got, 2'(1 << (i % 2)), 8'(i + 1));
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (bus.out_valid !== 2'b00 || cnt0 !== 2'd2 || cnt1 !== 2'd2) begin
      errors++;
      $display("FAIL rr_counts out_valid=%b cnt0=%0d cnt1=%0d required 00 2 2",
               bus.out_valid, cnt0, cnt1);
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    bus.out_ready = 2'b00;
    drive(1'b1, 1'b1, 8'h20);
    tick();
    // rr still 0 (select mode); channel 1 full, channel 0 empty.
    mode = 1'b1;
    enable = 1'b0;
    drive(1'b1, 1'b1, 8'h99);
    bus.out_ready = 2'b10;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_ready in_ready=%b required 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 2'b00 || cnt1 !== 2'd1 || bus.out_data0 !== 8'h00) begin
      errors++;
      $display("FAIL en_drain out_valid=%b cnt1=%0d d0=%h required 00 1 00",
               bus.out_valid, cnt1, bus.out_data0);
    end
    enable = 1'b1;
    bus.out_ready = 2'b00;
    drive(1'b1, 1'b0, 8'h5A);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.out_valid !== 2'b01 || bus.out_data0 !== 8'h5A) begin
      errors++;
      $display("FAIL en_rr_frozen out_valid=%b d0=%h required 01 5a", bus.out_valid, bus.out_data0);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp;
    do_reset();
    bus.out_ready = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 8'(k));
      tick();
      drive(1'b0, 1'b0, 8'h00);
      tick();
      exp = (k < 3) ? CNT_W'(k) : 2'd3;
      checks++;
      if (cnt0 !== exp) begin
        errors++;
        $display("FAIL sat_drain%0d cnt0=%0d required %0d", k, cnt0, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    mode = 1'b0;
    bus.out_ready = 2'b00;
    drive(1'b0, 1'b0, 8'h00);
    test_reset();
    test_select();
    test_backpressure();
    test_round_robin();
    test_enable_gating();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
